// File: rtl/user_rom_pipe.sv
// Pipelined read-only OBI subordinate with fixed response latency and an optional
// saturating read-hit counter mapped one word past the end of the ROM.
package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_rom_pipe #(
    parameter obi_pkg::obi_cfg_t     ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type                   obi_req_t = obi_pkg::obi_req_t,
    parameter type                   obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned           NumWords  = 8,
    parameter int unsigned           Latency   = 2,
    parameter logic [NumWords*32-1:0] RomInit  = '0,
    parameter bit                    CntEn     = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o
);

    localparam int unsigned IdxRaw = $clog2(NumWords + int'(CntEn));
    localparam int unsigned IdxW   = (IdxRaw > 1) ? IdxRaw : 1;
    localparam int unsigned IdW    = ObiCfg.IdWidth;

    if (Latency < 1 || Latency > 4) begin : g_bad_latency
        $error("user_rom_pipe: Latency must be in 1..4");
    end
    if (ObiCfg.DataWidth != 32) begin : g_bad_width
        $error("user_rom_pipe: DataWidth must be 32");
    end
    if (NumWords < 1) begin : g_bad_depth
        $error("user_rom_pipe: NumWords must be at least 1");
    end

    typedef struct packed {
        logic           valid;
        logic [IdW-1:0] rid;
        logic           err;
        logic [31:0]    rdata;
    } stage_t;

    logic [IdxW-1:0] idx;
    logic            aligned;
    logic            in_rom;
    logic            is_cnt;
    logic            full_be;
    logic            hit;
    logic            clr;
    logic [31:0]     rom_word;
    logic [31:0]     cnt_rd;
    stage_t          dec;
    stage_t          pipe_q [Latency];
    logic            unused_bits;

    assign idx     = obi_req_i.a.addr[IdxW+1:2];
    assign aligned = (obi_req_i.a.addr[1:0] == 2'b00);
    assign in_rom  = (32'(idx) < NumWords);
    assign is_cnt  = CntEn && (32'(idx) == NumWords);
    assign full_be = (obi_req_i.a.be == 4'hF);
    assign hit     = obi_req_i.req && aligned && !obi_req_i.a.we && in_rom;
    assign clr     = obi_req_i.req && aligned && obi_req_i.a.we && is_cnt && full_be;

    assign unused_bits = ^{obi_req_i.a.wdata, obi_req_i.a.addr[31:IdxW+2]};

    always_comb begin
        rom_word = '0;
        for (int unsigned w = 0; w < NumWords; w++) begin
            if (32'(idx) == w) rom_word = RomInit[32*w +: 32];
        end
    end

    always_comb begin
        dec = '0;
        if (obi_req_i.req) begin
            dec.valid = 1'b1;
            dec.rid   = obi_req_i.a.aid;
            if (!aligned) begin
                dec.err = 1'b1;
            end else if (!obi_req_i.a.we && in_rom) begin
                dec.rdata = rom_word;
            end else if (!obi_req_i.a.we && is_cnt) begin
                dec.rdata = cnt_rd;
            end else if (!(obi_req_i.a.we && is_cnt && full_be)) begin
                dec.err = 1'b1;
            end
        end
    end

    if (CntEn) begin : g_cnt
        logic [31:0] cnt_q;

        // Clear has priority over a hit; the count sticks at all-ones.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (clr) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign cnt_rd = cnt_q;
    end else begin : g_no_cnt
        logic unused_cnt;
        assign unused_cnt = ^{hit, clr};
        assign cnt_rd     = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Latency; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= dec;
            for (int unsigned i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = pipe_q[Latency-1].valid;
        obi_rsp_o.r.rdata = pipe_q[Latency-1].rdata;
        obi_rsp_o.r.rid   = pipe_q[Latency-1].rid;
        obi_rsp_o.r.err   = pipe_q[Latency-1].err;
    end

endmodule

// File: tb/tb_user_rom_pipe.sv
// Bench for user_rom_pipe: constant vector table, directed counter/reset sequences
// and random traffic against a byte-level ROM and counter model.
module tb_user_rom_pipe;

    localparam int unsigned NW   = 8;
    localparam int unsigned LAT  = 2;
    localparam bit          CNT  = 1'b1;
    localparam int unsigned IDXW = $clog2(NW + 1);
    localparam logic [NW*32-1:0] ROM_INIT = {
        32'h0BAD_F00D, 32'hCAFE_1234, 32'h1357_9BDF, 32'hDEAD_BEEF,
        32'h0000_0000, 32'h4349_5341, 32'h2073_274B, 32'h4C26_4E4C
    };

    logic              clk = 1'b0;
    logic              rst;
    obi_pkg::obi_req_t req;
    obi_pkg::obi_rsp_t rsp;

    user_rom_pipe #(
        .ObiCfg   (obi_pkg::ObiDefaultConfig),
        .obi_req_t(obi_pkg::obi_req_t),
        .obi_rsp_t(obi_pkg::obi_rsp_t),
        .NumWords (NW),
        .Latency  (LAT),
        .RomInit  (ROM_INIT),
        .CntEn    (CNT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .obi_req_i(req),
        .obi_rsp_o(rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  rid;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [3:0]  aid;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          k = 0;
    exp_t        q[$];
    logic [31:0] m_cnt;
    logic [31:0] rom_w [NW];
    vec_t        vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, k);
        end
    endtask

    task automatic init_model();
        string    txt;
        byte      bytes [NW*4];
        logic [31:0] tail [4];
        txt = "LN&LK's ASIC";
        foreach (bytes[i]) bytes[i] = 8'h00;
        for (int i = 0; i < txt.len(); i++) bytes[i] = txt[i];
        for (int w = 0; w < 4; w++)
            rom_w[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
        tail = '{32'hDEAD_BEEF, 32'h1357_9BDF, 32'hCAFE_1234, 32'h0BAD_F00D};
        for (int w = 4; w < 8; w++) rom_w[w] = tail[w-4];
        m_cnt = 32'h0;
    endtask

    // Decode from the address map; the counter reads pre-update, clear beats hit.
    task automatic model(input logic [31:0] a, input logic w, input logic [3:0] b,
                         output logic e, output logic [31:0] d);
        int unsigned idx;
        bit hit, clr;
        idx = (a >> 2) % (1 << IDXW);
        e = 1'b1; d = 32'h0; hit = 0; clr = 0;
        if (a % 4 != 0) begin
            e = 1'b1;
        end else if (!w && idx < NW) begin
            e = 1'b0; d = rom_w[idx]; hit = 1;
        end else if (!w && CNT && idx == NW) begin
            e = 1'b0; d = m_cnt;
        end else if (w && CNT && idx == NW && b == 4'hF) begin
            e = 1'b0; clr = 1;
        end
        if (clr) m_cnt = 32'h0;
        else if (hit && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic collect();
        if (q.size() > 0 && q[0].due == k) begin
            check("rvalid", 32'(rsp.rvalid), 32'h1);
            check("rid", 32'(rsp.r.rid), 32'(q[0].rid));
            check("err", 32'(rsp.r.err), 32'(q[0].err));
            check("rdata", rsp.r.rdata, q[0].rdata);
            void'(q.pop_front());
        end else begin
            check("rvalid_idle", 32'(rsp.rvalid), 32'h0);
        end
        k++;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [3:0] id, input bit use_exp, input logic ee, input logic [31:0] ed);
        logic        me;
        logic [31:0] md;
        @(negedge clk);
        req         = '0;
        req.req     = r;
        req.a.addr  = a;
        req.a.we    = w;
        req.a.be    = b;
        req.a.aid   = id;
        req.a.wdata = $urandom;
        if (r) begin
            model(a, w, b, me, md);
            if (use_exp) begin me = ee; md = ed; end
            q.push_back('{due: k + LAT - 1, rid: id, err: me, rdata: md});
        end
        #1 check("gnt", 32'(rsp.gnt), 32'(r));
        @(posedge clk);
        #1 collect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic reset_check();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req.req    = (i % 2 == 0);
            req.a.addr = 32'h4;
            #1;
            check("rst_rvalid", 32'(rsp.rvalid), 32'h0);
            check("rst_rdata", rsp.r.rdata, 32'h0);
            check("rst_err", 32'(rsp.r.err), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        init_model();

        // Reset held while req toggles, then counter must read zero.
        reset_check();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'h7, 1'b1, 1'b0, 32'h0);
        idle(2);

        vecs = '{
            '{32'h0000_0000, 1'b0, 4'hF, 4'h5, 1'b0, 32'h4C26_4E4C},
            '{32'h0000_0000, 1'b0, 4'hF, 4'h1, 1'b0, 32'h4C26_4E4C},
            '{32'h0000_0004, 1'b0, 4'hF, 4'h2, 1'b0, 32'h2073_274B},
            '{32'h0000_0008, 1'b0, 4'hF, 4'h3, 1'b0, 32'h4349_5341},
            '{32'h0000_0004, 1'b1, 4'hF, 4'h4, 1'b1, 32'h0},
            '{32'h0000_0002, 1'b0, 4'hF, 4'h5, 1'b1, 32'h0},
            '{32'h0000_0024, 1'b0, 4'hF, 4'h6, 1'b1, 32'h0},
            '{32'h0000_0004, 1'b0, 4'hF, 4'h7, 1'b0, 32'h2073_274B},
            '{32'h0000_001C, 1'b0, 4'h0, 4'h8, 1'b0, 32'h0BAD_F00D},
            '{32'h0000_0010, 1'b0, 4'hF, 4'h9, 1'b0, 32'hDEAD_BEEF},
            '{32'h0000_003C, 1'b0, 4'hF, 4'hA, 1'b1, 32'h0},
            '{32'hABCD_0040, 1'b0, 4'hF, 4'hB, 1'b0, 32'h4C26_4E4C},
            '{32'h0000_0020, 1'b1, 4'h7, 4'hC, 1'b1, 32'h0}
        };
        foreach (vecs[i])
            step(1'b1, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].aid, 1'b1, vecs[i].err, vecs[i].rdata);
        idle(2);

        // Counter: clear, three hits, read, clear, read, then hit directly before a clear.
        step(1'b1, 32'h20, 1'b1, 4'hF, 4'h1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0, 1'b0, 4'hF, 4'h2, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 4'hF, 4'h3, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 4'hF, 4'h4, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'h5, 1'b1, 1'b0, 32'h3);
        step(1'b1, 32'h20, 1'b1, 4'hF, 4'h6, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'h7, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0, 1'b0, 4'hF, 4'h8, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b1, 4'hF, 4'h9, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'hA, 1'b1, 1'b0, 32'h0);
        idle(2);

        // Reset half a cycle after a grant drops that response.
        step(1'b1, 32'h0, 1'b0, 4'hF, 4'h3, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        q.delete();
        m_cnt = 32'h0;
        #1 check("midrst_rvalid", 32'(rsp.rvalid), 32'h0);
        @(posedge clk);
        #1 check("midrst_rvalid2", 32'(rsp.rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_rvalid3", 32'(rsp.rvalid), 32'h0);
        idle(2);

        // Saturation: preload all-ones, then one more hit must not wrap.
        force dut.g_cnt.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.g_cnt.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b1, 32'h0, 1'b0, 4'hF, 4'h1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step(1'b1, 32'h4, 1'b0, 4'hF, 4'h3, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h20, 1'b0, 4'hF, 4'h4, 1'b1, 1'b0, 32'hFFFF_FFFF);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            logic        r, w;
            logic [3:0]  b;
            logic [31:0] a;
            int unsigned ix;
            r  = ($urandom_range(0, 4) != 0);
            ix = ($urandom_range(0, 3) == 0) ? NW : $urandom_range(0, 15);
            a  = ($urandom & 32'hFFFF_FFC0) | (ix << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            w  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            step(r, a, w, b, 4'($urandom), 1'b0, 1'b0, 32'h0);
        end
        idle(LAT + 1);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
